// File: rtl/tlp_rxcpl_writer.sv
// Upstream stage of the RX completion buffer: realigns 3DW-header completion payload into
// 128-bit lines, writes them into per-tag slots of the completion RAM and reports request completion.
module tlp_rxcpl_writer #(
  parameter int C_TAG_BITS  = 5,
  parameter int C_LINE_BITS = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [127:0]                      RxCplTData,
  input  logic                              RxCplTValid,
  input  logic                              RxCplTSof,
  input  logic                              RxCplTEof,
  output logic                              RxCplTReady,
  input  logic                              CplTagAlloc,
  input  logic [C_TAG_BITS-1:0]             CplTagAllocTag,
  output logic [C_TAG_BITS+C_LINE_BITS-1:0] RxCplRamWrAddr,
  output logic [129:0]                      RxCplRamWrDat,
  output logic                              RxCplRamWrEna,
  output logic                              RxCplDoneVld,
  output logic [C_TAG_BITS-1:0]             RxCplDoneTag,
  output logic                              RxCplDoneErr
);

  localparam int NUM_TAGS = 1 << C_TAG_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DROP  = 2'd3
  } cplState_t;

  // Number of 16-byte lines a payload of lenDw dwords occupies (0 encodes 1024 dwords).
  function automatic logic [8:0] linesNeeded(input logic [9:0] lenDw);
    logic [10:0] dwCnt;
    dwCnt = (lenDw == 10'd0) ? 11'd1024 : {1'b0, lenDw};
    return 9'((dwCnt + 11'd3) >> 2);
  endfunction

  cplState_t              stateR, stateNxt;
  logic [C_TAG_BITS-1:0]  tagR, tagNxt;
  logic                   lastReqR, lastReqNxt;
  logic [31:0]            holdR, holdNxt;
  logic [8:0]             needR, needNxt;
  logic [8:0]             cntR, cntNxt;
  logic [8:0]             cntInc;
  logic                   readyR;
  logic                   accept;

  logic [9:0]             hdrLen;
  logic [2:0]             hdrStatus;
  logic [11:0]            hdrByteCnt;
  logic [C_TAG_BITS-1:0]  hdrTag;

  logic                   wrDo;
  logic [C_TAG_BITS-1:0]  wrTag;
  logic [127:0]           wrData;
  logic                   wrLast;
  logic                   wrStatErr;
  logic [C_LINE_BITS-1:0] wrPtr;
  logic                   wrFull;
  logic                   slotErr;
  logic                   doneEvt;

  logic [C_LINE_BITS-1:0] ptrR [NUM_TAGS];
  logic [NUM_TAGS-1:0]    fullR;
  logic [NUM_TAGS-1:0]    errR;

  logic [C_TAG_BITS+C_LINE_BITS-1:0] wrAddrR;
  logic [129:0]           wrDatR;
  logic                   wrEnaR;
  logic                   doneVldR;
  logic [C_TAG_BITS-1:0]  doneTagR;
  logic                   doneErrR;

  assign accept     = RxCplTValid & readyR;
  assign hdrLen     = RxCplTData[9:0];
  assign hdrStatus  = RxCplTData[47:45];
  assign hdrByteCnt = RxCplTData[43:32];
  assign hdrTag     = RxCplTData[72 +: C_TAG_BITS];
  assign cntInc     = cntR + 9'd1;

  // Frame tracking, payload realignment and write request generation.
  always_comb begin
    stateNxt   = stateR;
    tagNxt     = tagR;
    lastReqNxt = lastReqR;
    holdNxt    = holdR;
    needNxt    = needR;
    cntNxt     = cntR;
    wrDo       = 1'b0;
    wrTag      = tagR;
    wrData     = 128'd0;
    wrLast     = 1'b0;
    wrStatErr  = 1'b0;
    case (stateR)
      ST_IDLE: begin
        if (accept && RxCplTSof) begin
          tagNxt     = hdrTag;
          lastReqNxt = (hdrByteCnt == {hdrLen, 2'b00});
          holdNxt    = RxCplTData[127:96];
          needNxt    = linesNeeded(hdrLen);
          cntNxt     = 9'd0;
          if (hdrStatus != 3'd0) begin
            // Unsuccessful completion: a single flagged line closes the request.
            wrDo      = 1'b1;
            wrTag     = hdrTag;
            wrLast    = 1'b1;
            wrStatErr = 1'b1;
            if (RxCplTEof) begin
              stateNxt = ST_IDLE;
            end else begin
              stateNxt = ST_DROP;
            end
          end else if (RxCplTEof) begin
            stateNxt = ST_FLUSH;
          end else begin
            stateNxt = ST_DATA;
          end
        end else begin
          stateNxt = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (accept) begin
          wrDo    = 1'b1;
          wrData  = {RxCplTData[95:0], holdR};
          holdNxt = RxCplTData[127:96];
          cntNxt  = cntInc;
          if (RxCplTEof) begin
            if (cntInc < needR) begin
              stateNxt = ST_FLUSH;
            end else begin
              wrLast   = 1'b1;
              stateNxt = ST_IDLE;
            end
          end else begin
            stateNxt = ST_DATA;
          end
        end else begin
          stateNxt = ST_DATA;
        end
      end
      ST_FLUSH: begin
        wrDo     = 1'b1;
        wrData   = {96'd0, holdR};
        wrLast   = 1'b1;
        cntNxt   = cntInc;
        stateNxt = ST_IDLE;
      end
      ST_DROP: begin
        if (accept && RxCplTEof) begin
          stateNxt = ST_IDLE;
        end else begin
          stateNxt = ST_DROP;
        end
      end
      default: begin
        stateNxt = ST_IDLE;
      end
    endcase
  end

  assign wrPtr   = ptrR[wrTag];
  assign wrFull  = fullR[wrTag];
  assign slotErr = errR[wrTag];
  assign doneEvt = wrDo & (wrStatErr | (wrLast & lastReqR));

  // Frame state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateR   <= ST_IDLE;
      tagR     <= {C_TAG_BITS{1'b0}};
      lastReqR <= 1'b0;
      holdR    <= 32'd0;
      needR    <= 9'd0;
      cntR     <= 9'd0;
      readyR   <= 1'b0;
    end else begin
      stateR   <= stateNxt;
      tagR     <= tagNxt;
      lastReqR <= lastReqNxt;
      holdR    <= holdNxt;
      needR    <= needNxt;
      cntR     <= cntNxt;
      readyR   <= (stateNxt != ST_FLUSH);
    end
  end

  // Per-tag line pointer, slot-full flag and sticky overflow error; allocation overrides a write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        ptrR[t] <= {C_LINE_BITS{1'b0}};
      end
      fullR <= {NUM_TAGS{1'b0}};
      errR  <= {NUM_TAGS{1'b0}};
    end else begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        if (CplTagAlloc && (CplTagAllocTag == C_TAG_BITS'(t))) begin
          ptrR[t]  <= {C_LINE_BITS{1'b0}};
          fullR[t] <= 1'b0;
          errR[t]  <= 1'b0;
        end else if (wrDo && (wrTag == C_TAG_BITS'(t))) begin
          if (doneEvt) begin
            ptrR[t]  <= {C_LINE_BITS{1'b0}};
            fullR[t] <= 1'b0;
            errR[t]  <= 1'b0;
          end else if (fullR[t]) begin
            errR[t] <= 1'b1;
          end else begin
            ptrR[t]  <= ptrR[t] + C_LINE_BITS'(1);
            fullR[t] <= (ptrR[t] == {C_LINE_BITS{1'b1}});
          end
        end
      end
    end
  end

  // Registered RAM write port and completion report; a full slot never wraps into another tag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrAddrR  <= {(C_TAG_BITS+C_LINE_BITS){1'b0}};
      wrDatR   <= 130'd0;
      wrEnaR   <= 1'b0;
      doneVldR <= 1'b0;
      doneTagR <= {C_TAG_BITS{1'b0}};
      doneErrR <= 1'b0;
    end else begin
      wrEnaR   <= wrDo & ~wrFull;
      doneVldR <= doneEvt;
      if (wrDo) begin
        wrAddrR <= {wrTag, wrPtr};
        wrDatR  <= wrStatErr ? {2'b11, 128'd0} : {1'b0, wrLast & lastReqR, wrData};
      end
      if (doneEvt) begin
        doneTagR <= wrTag;
        doneErrR <= wrStatErr | slotErr | wrFull;
      end
    end
  end

  assign RxCplTReady    = readyR;
  assign RxCplRamWrAddr = wrAddrR;
  assign RxCplRamWrDat  = wrDatR;
  assign RxCplRamWrEna  = wrEnaR;
  assign RxCplDoneVld   = doneVldR;
  assign RxCplDoneTag   = doneTagR;
  assign RxCplDoneErr   = doneErrR;

endmodule

// File: tb/tb_tlp_rxcpl_writer.sv
// Table-driven bench for tlp_rxcpl_writer: each vector is one clock of stimulus plus the
// outputs expected right after that clock edge.
module tb_tlp_rxcpl_writer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] RxCplTData;
  logic         RxCplTValid;
  logic         RxCplTSof;
  logic         RxCplTEof;
  logic         RxCplTReady;
  logic         CplTagAlloc;
  logic [4:0]   CplTagAllocTag;
  logic [8:0]   RxCplRamWrAddr;
  logic [129:0] RxCplRamWrDat;
  logic         RxCplRamWrEna;
  logic         RxCplDoneVld;
  logic [4:0]   RxCplDoneTag;
  logic         RxCplDoneErr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tlp_rxcpl_writer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .RxCplTData     (RxCplTData),
    .RxCplTValid    (RxCplTValid),
    .RxCplTSof      (RxCplTSof),
    .RxCplTEof      (RxCplTEof),
    .RxCplTReady    (RxCplTReady),
    .CplTagAlloc    (CplTagAlloc),
    .CplTagAllocTag (CplTagAllocTag),
    .RxCplRamWrAddr (RxCplRamWrAddr),
    .RxCplRamWrDat  (RxCplRamWrDat),
    .RxCplRamWrEna  (RxCplRamWrEna),
    .RxCplDoneVld   (RxCplDoneVld),
    .RxCplDoneTag   (RxCplDoneTag),
    .RxCplDoneErr   (RxCplDoneErr)
  );

  typedef struct {
    logic         rst;
    logic         valid;
    logic         sof;
    logic         eof;
    logic [127:0] data;
    logic         alloc;
    logic [4:0]   allocTag;
    logic         expReady;
    logic         expEna;
    logic [8:0]   expAddr;
    logic [129:0] expDat;
    logic         expDone;
    logic [4:0]   expDoneTag;
    logic         expDoneErr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] dw(input logic [15:0] salt, input int i);
    return {salt, 16'(i)};
  endfunction

  function automatic logic [127:0] beatDat(input logic [15:0] salt, input int k);
    return {dw(salt, 4*k), dw(salt, 4*k-1), dw(salt, 4*k-2), dw(salt, 4*k-3)};
  endfunction

  function automatic logic [127:0] lineDat(input logic [15:0] salt, input int k);
    return {dw(salt, 4*k-1), dw(salt, 4*k-2), dw(salt, 4*k-3), dw(salt, 4*k-4)};
  endfunction

  function automatic logic [127:0] hdrBeat(input logic [9:0] len, input logic [2:0] status,
                                           input logic [11:0] bc, input logic [4:0] tag,
                                           input logic [15:0] salt);
    return {dw(salt, 0), {19'd0, tag, 8'd0}, {16'd0, status, 1'b0, bc}, {22'd0, len}};
  endfunction

  function automatic vec_t idleVec();
    vec_t v;
    v = '{default: '0};
    v.expReady = 1'b1;
    return v;
  endfunction

  // Appends one successful completion TLP; expected addresses, last/flush and drop points are given by the caller.
  task automatic addTlp(input logic [4:0] tag, input logic [9:0] len, input logic [11:0] bc,
                        input int nData, input logic [15:0] salt, input logic [8:0] base,
                        input logic expLast, input logic expFlush, input int dropFrom,
                        input logic expErr, input logic gaps);
    vec_t v;
    logic tail;
    v = idleVec();
    v.valid = 1'b1; v.sof = 1'b1; v.eof = (nData == 0);
    v.data = hdrBeat(len, 3'd0, bc, tag, salt);
    v.expReady = !((nData == 0) && expFlush);
    vecs.push_back(v);
    for (int k = 1; k <= nData; k++) begin
      if (gaps) begin
        v = idleVec();
        v.sof = 1'b1; v.eof = 1'b1; v.data = {4{32'hDEAD_BEEF}};
        vecs.push_back(v);
      end
      tail = (k == nData) && !expFlush && expLast;
      v = idleVec();
      v.valid = 1'b1; v.eof = (k == nData); v.data = beatDat(salt, k);
      v.expEna = (k < dropFrom);
      v.expAddr = base + 9'(k - 1);
      v.expDat = {1'b0, tail, lineDat(salt, k)};
      v.expDone = tail;
      v.expDoneTag = tag;
      v.expDoneErr = expErr;
      v.expReady = !((k == nData) && expFlush);
      vecs.push_back(v);
    end
    if (expFlush) begin
      v = idleVec();
      v.expEna = 1'b1;
      v.expAddr = base + 9'(nData);
      v.expDat = {1'b0, expLast, 96'd0, dw(salt, 4*nData)};
      v.expDone = expLast;
      v.expDoneTag = tag;
      v.expDoneErr = expErr;
      vecs.push_back(v);
    end
  endtask

  task automatic check(input string name, input int idx, input logic [129:0] act, input logic [129:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic applyVec(input vec_t v, input int idx);
    rst_n          = ~v.rst;
    RxCplTValid    = v.valid;
    RxCplTSof      = v.sof;
    RxCplTEof      = v.eof;
    RxCplTData     = v.data;
    CplTagAlloc    = v.alloc;
    CplTagAllocTag = v.allocTag;
    @(posedge clk);
    #1;
    check("ready", idx, 130'(RxCplTReady), 130'(v.expReady));
    check("wrEna", idx, 130'(RxCplRamWrEna), 130'(v.expEna));
    if (v.expEna) begin
      check("wrAddr", idx, 130'(RxCplRamWrAddr), 130'(v.expAddr));
      check("wrDat", idx, RxCplRamWrDat, v.expDat);
    end
    check("doneVld", idx, 130'(RxCplDoneVld), 130'(v.expDone));
    if (v.expDone) begin
      check("doneTag", idx, 130'(RxCplDoneTag), 130'(v.expDoneTag));
      check("doneErr", idx, 130'(RxCplDoneErr), 130'(v.expDoneErr));
    end
    if (v.rst) begin
      check("rstAddr", idx, 130'(RxCplRamWrAddr), 130'd0);
      check("rstDat", idx, RxCplRamWrDat, 130'd0);
    end
  endtask

  initial begin
    vec_t v;
    logic [127:0] urBeat;

    rst_n = 1'b0; RxCplTValid = 1'b0; RxCplTSof = 1'b0; RxCplTEof = 1'b0;
    RxCplTData = 128'd0; CplTagAlloc = 1'b0; CplTagAllocTag = 5'd0;

    // Reset: outputs quiet and Ready low while held, Ready high one cycle after release.
    repeat (3) @(posedge clk);
    #1;
    check("rstReady", -1, 130'(RxCplTReady), 130'd0);
    check("rstEna", -1, 130'(RxCplRamWrEna), 130'd0);
    check("rstDone", -1, 130'(RxCplDoneVld), 130'd0);
    check("rstDoneTag", -1, 130'(RxCplDoneTag), 130'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("readyAfterRst", -1, 130'(RxCplTReady), 130'd1);

    // CplD tag 3, len 8, bc 32: two full lines at 0x030/0x031, done.
    addTlp(5'd3, 10'd8, 12'd32, 2, 16'h0300, 9'h030, 1'b1, 1'b0, 99, 1'b0, 1'b0);

    // CplD tag 1, len 1, sof&eof: flush bubble; a UR Cpl is held on the bus through the bubble.
    addTlp(5'd1, 10'd1, 12'd4, 0, 16'h0100, 9'h010, 1'b1, 1'b1, 99, 1'b0, 1'b0);
    urBeat = hdrBeat(10'd0, 3'b001, 12'd64, 5'd7, 16'h0700);
    vecs[vecs.size()-1].valid = 1'b1;
    vecs[vecs.size()-1].sof   = 1'b1;
    vecs[vecs.size()-1].eof   = 1'b1;
    vecs[vecs.size()-1].data  = urBeat;
    v = idleVec();
    v.valid = 1'b1; v.sof = 1'b1; v.eof = 1'b1; v.data = urBeat;
    v.expEna = 1'b1; v.expAddr = 9'h070; v.expDat = {2'b11, 128'd0};
    v.expDone = 1'b1; v.expDoneTag = 5'd7; v.expDoneErr = 1'b1;
    vecs.push_back(v);

    // Ragged tail: len 5 needs a flushed second line.
    addTlp(5'd8, 10'd5, 12'd20, 1, 16'h0800, 9'h080, 1'b1, 1'b1, 99, 1'b0, 1'b0);

    // 256B request on tag 2 split into two 128B completions, one done pulse.
    addTlp(5'd2, 10'd32, 12'd256, 8, 16'h0200, 9'h020, 1'b0, 1'b0, 99, 1'b0, 1'b0);
    addTlp(5'd2, 10'd32, 12'd128, 8, 16'h0201, 9'h028, 1'b1, 1'b0, 99, 1'b0, 1'b0);

    // len 16 on tag 4 back-to-back, then identical TLP with valid toggling.
    addTlp(5'd4, 10'd16, 12'd64, 4, 16'h0400, 9'h040, 1'b1, 1'b0, 99, 1'b0, 1'b0);
    addTlp(5'd4, 10'd16, 12'd64, 4, 16'h0400, 9'h040, 1'b1, 1'b0, 99, 1'b0, 1'b1);

    // Alloc of tag 5 coincides with its write; then 17 lines on tag 5 overflow; then a clean request.
    addTlp(5'd5, 10'd4, 12'd100, 1, 16'h0500, 9'h050, 1'b0, 1'b0, 99, 1'b0, 1'b0);
    vecs[vecs.size()-1].alloc    = 1'b1;
    vecs[vecs.size()-1].allocTag = 5'd5;
    addTlp(5'd5, 10'd68, 12'd272, 17, 16'h0501, 9'h050, 1'b1, 1'b0, 17, 1'b1, 1'b0);
    addTlp(5'd5, 10'd4, 12'd16, 1, 16'h0502, 9'h050, 1'b1, 1'b0, 99, 1'b0, 1'b0);

    // Reset mid-TLP on tag 6: partial request discarded, pointer restarts at line 0.
    v = idleVec();
    v.valid = 1'b1; v.sof = 1'b1; v.data = hdrBeat(10'd8, 3'd0, 12'd32, 5'd6, 16'h0600);
    vecs.push_back(v);
    v = idleVec();
    v.valid = 1'b1; v.data = beatDat(16'h0600, 1);
    v.expEna = 1'b1; v.expAddr = 9'h060; v.expDat = {2'b00, lineDat(16'h0600, 1)};
    vecs.push_back(v);
    for (int r = 0; r < 2; r++) begin
      v = idleVec();
      v.rst = 1'b1; v.expReady = 1'b0;
      vecs.push_back(v);
    end
    vecs.push_back(idleVec());
    addTlp(5'd6, 10'd8, 12'd32, 2, 16'h0601, 9'h060, 1'b1, 1'b0, 99, 1'b0, 1'b0);
    vecs.push_back(idleVec());

    for (int i = 0; i < vecs.size(); i++) begin
      applyVec(vecs[i], i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
